sdram_burst_sched: RTL

- Burst scheduler between the user FIFO pair (write FIFO, read FIFO) and the SDRAM command controller.
- Decides when each of three operations runs: an auto-refresh, a write burst (drains the write FIFO into SDRAM) or a read burst (fills the read FIFO from SDRAM).
- Generates the burst start addresses and wraps them inside the programmed [b_addr, e_addr) windows.
- Only one operation is outstanding at a time; each completes through a req/end handshake with the controller.

---
 rtl/sdram_burst_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sdram_burst_sched.sv
// ---------------------------------------------------------------------------
// sdram_burst_sched
//   Burst scheduler between the user write/read FIFO pair and the SDRAM
//   command controller. It picks one operation at a time (auto-refresh, write
//   burst or read burst), generates the burst start addresses and wraps each
//   address inside its programmed [b_addr, e_addr) window. Each operation is
//   finished by a req/end handshake with the controller.
//
// Ports
//   sys_clk, sys_rst_n          clock, asynchronous active-low reset
//   init_end                    SDRAM power-up init complete (level)
//   aref_req                    refresh due (level, held until serviced)
//   aref_end, wr_end, rd_end    operation complete, 1-cycle pulses
//   wr_fifo_num, rd_fifo_num    FIFO fill levels
//   read_valid                  reads permitted
//   wr_b_addr/wr_e_addr         write window start / exclusive end
//   rd_b_addr/rd_e_addr         read window start / exclusive end
//   wr_burst_len, rd_burst_len  words per burst (nonzero)
//   wr_addr_rst, rd_addr_rst    pulse: return pointer to its window start
//   aref_en, wr_req, rd_req     registered grants / requests (one-hot or 0)
//   wr_addr, rd_addr            registered burst start addresses
//   last_was_wr                 last completed burst was a write
// ---------------------------------------------------------------------------
module sdram_burst_sched #(
  parameter int ADDR_W = 23,
  parameter int LEN_W  = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic              wr_end,
  input  logic              rd_end,
  input  logic [LEN_W-1:0]  wr_fifo_num,
  input  logic [LEN_W-1:0]  rd_fifo_num,
  input  logic              read_valid,
  input  logic [ADDR_W-1:0] wr_b_addr,
  input  logic [ADDR_W-1:0] wr_e_addr,
  input  logic [ADDR_W-1:0] rd_b_addr,
  input  logic [ADDR_W-1:0] rd_e_addr,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic              wr_addr_rst,
  input  logic              rd_addr_rst,
  output logic              aref_en,
  output logic              wr_req,
  output logic              rd_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              last_was_wr
);

  typedef enum logic [2:0] {
    S_INIT,
    S_ARB,
    S_AREF,
    S_WRITE,
    S_READ
  } state_t;

  state_t state;
  logic   wr_rst_pend;
  logic   rd_rst_pend;

  // Next-burst address one bit wider than the pointer, and the end-of-burst
  // check two bits wider, so neither sum can overflow before the compare.
  logic [ADDR_W:0]   wr_nxt, rd_nxt;
  logic [ADDR_W+1:0] wr_chk, rd_chk;
  logic [ADDR_W-1:0] wr_adv, rd_adv;
  logic [LEN_W:0]    rd_room;
  logic              wr_ok, rd_ok;

  assign wr_nxt = {1'b0, wr_addr} + (ADDR_W+1)'(wr_burst_len);
  assign rd_nxt = {1'b0, rd_addr} + (ADDR_W+1)'(rd_burst_len);
  assign wr_chk = {1'b0, wr_nxt} + (ADDR_W+2)'(wr_burst_len);
  assign rd_chk = {1'b0, rd_nxt} + (ADDR_W+2)'(rd_burst_len);

  // When the following burst would not fit in the window, restart at b_addr.
  // Otherwise nxt is below e_addr, so truncating it is lossless.
  assign wr_adv = (wr_chk > (ADDR_W+2)'(wr_e_addr)) ? wr_b_addr : wr_nxt[ADDR_W-1:0];
  assign rd_adv = (rd_chk > (ADDR_W+2)'(rd_e_addr)) ? rd_b_addr : rd_nxt[ADDR_W-1:0];

  // Read burst allowed only if the read FIFO can absorb the whole burst.
  assign rd_room = {1'b0, rd_fifo_num} + {1'b0, rd_burst_len};
  assign wr_ok   = (wr_fifo_num >= wr_burst_len);
  assign rd_ok   = read_valid && (rd_room <= {1'b0, {LEN_W{1'b1}}});

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below sees the pre-edge register values regardless of
  // statement order; later assignments in the block override earlier ones.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= S_INIT;
      aref_en     <= 1'b0;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      wr_addr     <= '0;
      rd_addr     <= '0;
      last_was_wr <= 1'b0;
      wr_rst_pend <= 1'b0;
      rd_rst_pend <= 1'b0;
    end else if (!init_end) begin
      // Losing init drops everything back to INIT and reloads the pointers.
      state       <= S_INIT;
      aref_en     <= 1'b0;
      wr_req      <= 1'b0;
      rd_req      <= 1'b0;
      wr_addr     <= wr_b_addr;
      rd_addr     <= rd_b_addr;
      wr_rst_pend <= 1'b0;
      rd_rst_pend <= 1'b0;
    end else begin
      // Pointer reset outside that pointer's own burst applies immediately.
      if (wr_addr_rst && state != S_WRITE) wr_addr <= wr_b_addr;
      if (rd_addr_rst && state != S_READ)  rd_addr <= rd_b_addr;

      case (state)
        S_INIT: begin
          wr_addr     <= wr_b_addr;
          rd_addr     <= rd_b_addr;
          wr_rst_pend <= 1'b0;
          rd_rst_pend <= 1'b0;
          state       <= S_ARB;
        end

        S_ARB: begin
          if (aref_req) begin
            state   <= S_AREF;
            aref_en <= 1'b1;
          end else if (wr_ok && rd_ok) begin
            // Both ready: alternate, starting with the one not done last.
            if (last_was_wr) begin
              state  <= S_READ;
              rd_req <= 1'b1;
            end else begin
              state  <= S_WRITE;
              wr_req <= 1'b1;
            end
          end else if (wr_ok) begin
            state  <= S_WRITE;
            wr_req <= 1'b1;
          end else if (rd_ok) begin
            state  <= S_READ;
            rd_req <= 1'b1;
          end
        end

        S_AREF: begin
          if (aref_end) begin
            aref_en <= 1'b0;
            state   <= S_ARB;
          end
        end

        S_WRITE: begin
          if (wr_addr_rst) wr_rst_pend <= 1'b1;
          if (wr_end) begin
            wr_req      <= 1'b0;
            state       <= S_ARB;
            last_was_wr <= 1'b1;
            wr_rst_pend <= 1'b0;
            wr_addr     <= (wr_rst_pend || wr_addr_rst) ? wr_b_addr : wr_adv;
          end
        end

        S_READ: begin
          if (rd_addr_rst) rd_rst_pend <= 1'b1;
          if (rd_end) begin
            rd_req      <= 1'b0;
            state       <= S_ARB;
            last_was_wr <= 1'b0;
            rd_rst_pend <= 1'b0;
            rd_addr     <= (rd_rst_pend || rd_addr_rst) ? rd_b_addr : rd_adv;
          end
        end

        default: begin
          state   <= S_INIT;
          aref_en <= 1'b0;
          wr_req  <= 1'b0;
          rd_req  <= 1'b0;
        end
      endcase
    end
  end

endmodule
